// File: rtl/control_unit.sv
// Hardwired control sequencer for the Mini-SRC datapath: fetch in T0..T2, then a
// per-opcode execute sequence; DIV holds its divide step for DIV_CYCLES cycles.
module control_unit #(
    parameter int DIV_CYCLES = 34
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic [15:0] DPin,
    output logic [15:0] DPout,
    output logic [15:0] ALUopp,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        RAM_wr,
    output logic        CONin,
    output logic        run
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                           OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                           OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                           OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
                           OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                           OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001,
                           OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JAL  = 5'b10100,
                           OP_JR   = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                           OP_MFLO = 5'b11000, OP_MFHI = 5'b11001, OP_HALT = 5'b11011;

    localparam int PC = 0, IRB = 1, YB = 2, MAR = 3, MDR = 4, INPORT = 5, OUTPORT = 6,
                   ZB = 7, ZHI = 8, ZLO = 9, HI = 10, LO = 11, READ = 12, CB = 13;
    localparam int A_ADD = 0, A_SUB = 1, A_NEG = 2, A_MUL = 3, A_DIV = 4, A_AND = 5,
                   A_OR = 6, A_ROR = 7, A_ROL = 8, A_SLL = 9, A_SRA = 10, A_SRL = 11,
                   A_NOT = 12, A_INC = 13;
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic [4:0]     op;
    logic [15:0]    alu_sel;
    logic           is_alu_r, is_alu_i, is_unary, is_muldiv, is_mem, is_short;
    logic           div_done;
    logic           unused_ir_bits;

    assign op             = IR[31:27];
    assign unused_ir_bits = ^IR[26:0];
    assign div_done       = (cnt == CW'(DIV_CYCLES - 1));

    // Opcode classification and the ALU operation each class requests.
    always_comb begin
        alu_sel   = '0;
        is_alu_r  = 1'b0;
        is_alu_i  = 1'b0;
        is_unary  = 1'b0;
        is_muldiv = 1'b0;
        is_mem    = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
        is_short  = (op == OP_JR) || (op == OP_IN) || (op == OP_OUT) ||
                    (op == OP_MFHI) || (op == OP_MFLO);
        case (op)
            OP_ADD:  begin is_alu_r = 1'b1; alu_sel[A_ADD] = 1'b1; end
            OP_SUB:  begin is_alu_r = 1'b1; alu_sel[A_SUB] = 1'b1; end
            OP_AND:  begin is_alu_r = 1'b1; alu_sel[A_AND] = 1'b1; end
            OP_OR:   begin is_alu_r = 1'b1; alu_sel[A_OR]  = 1'b1; end
            OP_ROR:  begin is_alu_r = 1'b1; alu_sel[A_ROR] = 1'b1; end
            OP_ROL:  begin is_alu_r = 1'b1; alu_sel[A_ROL] = 1'b1; end
            OP_SHR:  begin is_alu_r = 1'b1; alu_sel[A_SRL] = 1'b1; end
            OP_SHRA: begin is_alu_r = 1'b1; alu_sel[A_SRA] = 1'b1; end
            OP_SHL:  begin is_alu_r = 1'b1; alu_sel[A_SLL] = 1'b1; end
            OP_ADDI: begin is_alu_i = 1'b1; alu_sel[A_ADD] = 1'b1; end
            OP_ANDI: begin is_alu_i = 1'b1; alu_sel[A_AND] = 1'b1; end
            OP_ORI:  begin is_alu_i = 1'b1; alu_sel[A_OR]  = 1'b1; end
            OP_NEG:  begin is_unary = 1'b1; alu_sel[A_NEG] = 1'b1; end
            OP_NOT:  begin is_unary = 1'b1; alu_sel[A_NOT] = 1'b1; end
            OP_MUL:  begin is_muldiv = 1'b1; alu_sel[A_MUL] = 1'b1; end
            OP_DIV:  begin is_muldiv = 1'b1; alu_sel[A_DIV] = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state <= S_RESET;
        else     state <= state_next;
    end

    // Divide step counter: idles at zero, so entering T4 always starts from 0.
    always_ff @(posedge clk) begin
        if (clr || state != S_T4) cnt <= '0;
        else                      cnt <= cnt + 1'b1;
    end

    always_comb begin
        state_next = S_T0;
        case (state)
            S_RESET:  state_next = S_T0;
            S_T0:     state_next = S_T1;
            S_T1:     state_next = S_T2;
            S_T2: begin
                if (op == OP_HALT) state_next = S_HALTED;
                else if (is_alu_r || is_alu_i || is_unary || is_muldiv || is_mem ||
                         is_short || op == OP_BR || op == OP_JAL)
                    state_next = S_T3;
                else state_next = S_T0;
            end
            S_T3:     state_next = is_short ? S_T0 : S_T4;
            S_T4: begin
                if (is_unary || op == OP_JAL)        state_next = S_T0;
                else if (op == OP_BR)                state_next = CON ? S_T5 : S_T0;
                else if (op == OP_DIV && !div_done)  state_next = S_T4;
                else                                 state_next = S_T5;
            end
            S_T5:     state_next = (is_alu_r || is_alu_i || op == OP_LDI) ? S_T0 : S_T6;
            S_T6:     state_next = (op == OP_LD || op == OP_ST) ? S_T7 : S_T0;
            S_T7:     state_next = S_T0;
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_RESET;
        endcase
    end

    always_comb begin
        DPin   = '0;
        DPout  = '0;
        ALUopp = '0;
        Gra    = 1'b0;
        Grb    = 1'b0;
        Grc    = 1'b0;
        Rin    = 1'b0;
        Rout   = 1'b0;
        BAout  = 1'b0;
        RAM_wr = 1'b0;
        CONin  = 1'b0;
        run    = (state != S_RESET) && (state != S_HALTED);
        case (state)
            S_T0: begin DPout[PC] = 1'b1; DPin[MAR] = 1'b1; ALUopp[A_INC] = 1'b1; DPin[ZB] = 1'b1; end
            S_T1: begin DPout[ZLO] = 1'b1; DPin[PC] = 1'b1; DPin[MDR] = 1'b1; DPin[READ] = 1'b1; end
            S_T2: begin DPout[MDR] = 1'b1; DPin[IRB] = 1'b1; end
            S_T3: begin
                if (is_alu_r || is_alu_i) begin Rout = 1'b1; Grb = 1'b1; DPin[YB] = 1'b1; end
                else if (is_unary)  begin Rout = 1'b1; Grb = 1'b1; ALUopp = alu_sel; DPin[ZB] = 1'b1; end
                else if (is_muldiv) begin Rout = 1'b1; Gra = 1'b1; DPin[YB] = 1'b1; end
                else if (is_mem)    begin Grb = 1'b1; BAout = 1'b1; DPin[YB] = 1'b1; end
                else if (op == OP_BR)   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                else if (op == OP_JAL)  begin DPout[PC] = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                else if (op == OP_JR)   begin Gra = 1'b1; Rout = 1'b1; DPin[PC] = 1'b1; end
                else if (op == OP_IN)   begin DPout[INPORT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (op == OP_OUT)  begin Gra = 1'b1; Rout = 1'b1; DPin[OUTPORT] = 1'b1; end
                else if (op == OP_MFHI) begin DPout[HI] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (op == OP_MFLO) begin DPout[LO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            S_T4: begin
                if (is_alu_r)       begin Rout = 1'b1; Grc = 1'b1; ALUopp = alu_sel; DPin[ZB] = 1'b1; end
                else if (is_alu_i)  begin DPout[CB] = 1'b1; ALUopp = alu_sel; DPin[ZB] = 1'b1; end
                else if (is_unary)  begin DPout[ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_muldiv) begin Rout = 1'b1; Grb = 1'b1; ALUopp = alu_sel; DPin[ZB] = 1'b1; end
                else if (is_mem)    begin DPout[CB] = 1'b1; ALUopp[A_ADD] = 1'b1; DPin[ZB] = 1'b1; end
                else if (op == OP_BR && CON) begin DPout[PC] = 1'b1; DPin[YB] = 1'b1; end
                else if (op == OP_JAL) begin Gra = 1'b1; Rout = 1'b1; DPin[PC] = 1'b1; end
            end
            S_T5: begin
                if (is_alu_r || is_alu_i || op == OP_LDI) begin DPout[ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_muldiv) begin DPout[ZLO] = 1'b1; DPin[LO] = 1'b1; end
                else if (is_mem)    begin DPout[ZLO] = 1'b1; DPin[MAR] = 1'b1; end
                else if (op == OP_BR) begin DPout[CB] = 1'b1; ALUopp[A_ADD] = 1'b1; DPin[ZB] = 1'b1; end
            end
            S_T6: begin
                if (is_muldiv)        begin DPout[ZHI] = 1'b1; DPin[HI] = 1'b1; end
                else if (op == OP_LD) begin DPin[MDR] = 1'b1; DPin[READ] = 1'b1; end
                else if (op == OP_ST) begin DPin[MDR] = 1'b1; Gra = 1'b1; Rout = 1'b1; end
                else if (op == OP_BR) begin DPout[ZLO] = 1'b1; DPin[PC] = 1'b1; end
            end
            S_T7: begin
                if (op == OP_LD)      begin DPout[MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (op == OP_ST) RAM_wr = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
